// File: rtl/rv32i_pkg.sv
// rv32i_pkg: flag bit indices, branch funct3 codes and branch FSM encoding shared by the ALU and branch resolve unit
package rv32i_pkg;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_REDIRECT, ST_FLUSH} bru_state_t;
endpackage

// File: rtl/branch_cond_decode.sv
// branch_cond_decode: funct3 + {Z,C,V,N} flags -> taken, illegal (funct3 010/011); purely combinational
module branch_cond_decode
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] flags,
  output logic       taken,
  output logic       illegal
);
  logic lt;
  always_comb begin
    lt      = flags[FLAG_N] ^ flags[FLAG_V];
    taken   = funct3 == F3_BEQ  ?  flags[FLAG_Z] :
              funct3 == F3_BNE  ? ~flags[FLAG_Z] :
              funct3 == F3_BLT  ?  lt :
              funct3 == F3_BGE  ? ~lt :
              funct3 == F3_BLTU ?  flags[FLAG_C] :
              funct3 == F3_BGEU ? ~flags[FLAG_C] : 1'b0;
    illegal = funct3[2:1] == 2'b01;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branches/jumps in Execute, raises a held redirect on mispredict, then flushes D/E for FLUSH_CYCLES; BRU_STATS_EN adds BranchCount/MispredCount
module branch_resolve_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic [2:0]      Funct3E,
  input  logic [3:0]      FlagsE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] PCPlus4E,
  output logic            RedirectValid,
  input  logic            RedirectReady,
  output logic [XLEN-1:0] RedirectPC,
  output logic            StallE,
  output logic            FlushD,
  output logic            FlushE,
`ifdef BRU_STATS_EN
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MispredCount,
`endif
  output logic            IllegalBranch
);
  bru_state_t state;
  logic [3:0] cnt;
  logic cond_taken, cond_illegal, sample, taken, mispred;
  branch_cond_decode u_dec (
    .funct3 (Funct3E),
    .flags  (FlagsE),
    .taken  (cond_taken),
    .illegal(cond_illegal)
  );
  always_comb begin
    sample  = BranchE | JumpE;
    taken   = JumpE | (BranchE & cond_taken);
    mispred = sample & (taken != PredTakenE);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      RedirectValid <= 1'b0;
      RedirectPC    <= '0;
      StallE        <= 1'b0;
      FlushD        <= 1'b0;
      FlushE        <= 1'b0;
      IllegalBranch <= 1'b0;
    end else begin
      IllegalBranch <= 1'b0;
      case (state)
        ST_IDLE: begin
          IllegalBranch <= BranchE & ~JumpE & cond_illegal;
          if (mispred) begin
            state         <= ST_REDIRECT;
            RedirectPC    <= taken ? PCTargetE : PCPlus4E;
            RedirectValid <= 1'b1;
            StallE        <= 1'b1;
          end
        end
        ST_REDIRECT: if (RedirectReady) begin
          state         <= ST_FLUSH;
          cnt           <= 4'(FLUSH_CYCLES - 1);
          RedirectValid <= 1'b0;
          StallE        <= 1'b0;
          FlushD        <= 1'b1;
          FlushE        <= 1'b1;
        end
        ST_FLUSH: if (cnt == 4'd0) begin
          state  <= ST_IDLE;
          FlushD <= 1'b0;
          FlushE <= 1'b0;
        end else cnt <= cnt - 4'd1;
        default: state <= ST_IDLE;
      endcase
    end
  end
`ifdef BRU_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else if (state == ST_IDLE) begin
      BranchCount  <= BranchCount + CNT_W'(sample);
      MispredCount <= MispredCount + CNT_W'(mispred);
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        BranchE = 0, JumpE = 0, PredTakenE = 0, RedirectReady = 0;
  logic [2:0]  Funct3E = 0;
  logic [3:0]  FlagsE = 0;
  logic [31:0] PCTargetE = 0, PCPlus4E = 0;
  logic        RedirectValid, StallE, FlushD, FlushE, IllegalBranch;
  logic [31:0] RedirectPC;
`ifdef BRU_STATS_EN
  logic [31:0] BranchCount, MispredCount;
`endif
  int n_chk = 0, n_fail = 0;
  branch_resolve_unit dut (
    .CLK(CLK), .RST(RST), .BranchE(BranchE), .JumpE(JumpE), .Funct3E(Funct3E),
    .FlagsE(FlagsE), .PredTakenE(PredTakenE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
    .RedirectValid(RedirectValid), .RedirectReady(RedirectReady), .RedirectPC(RedirectPC),
    .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
`ifdef BRU_STATS_EN
    .BranchCount(BranchCount), .MispredCount(MispredCount),
`endif
    .IllegalBranch(IllegalBranch)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge CLK);
    @(negedge CLK);
  endtask
  task automatic issue(input logic b, input logic j, input logic [2:0] f3, input logic [3:0] fl,
                       input logic pr, input logic [31:0] tgt, input logic [31:0] p4);
    BranchE = b; JumpE = j; Funct3E = f3; FlagsE = fl; PredTakenE = pr;
    PCTargetE = tgt; PCPlus4E = p4;
    step();
    BranchE = 0; JumpE = 0;
  endtask
  // {RedirectValid, StallE, FlushD, FlushE, IllegalBranch}
  function automatic logic [31:0] outs();
    return {27'd0, RedirectValid, StallE, FlushD, FlushE, IllegalBranch};
  endfunction
  task automatic flush2(input string tag);
    chk({tag, "_flush1"}, outs(), 32'b00110);
    step();
    chk({tag, "_flush2"}, outs(), 32'b00110);
    step();
    chk({tag, "_idle"}, outs(), 32'b00000);
  endtask
  initial begin
    @(negedge CLK);
    step();
    step();
    chk("reset_outs", outs(), 32'b0);
    chk("reset_pc", RedirectPC, 32'h0);
    RST = 0;
    step();
    // 1: BEQ taken, predicted not taken, accepted on first REDIRECT cycle
    RedirectReady = 1;
    issue(1, 0, 3'b000, 4'b1000, 0, 32'h100, 32'h14);
    chk("t1_redirect", outs(), 32'b11000);
    chk("t1_pc", RedirectPC, 32'h100);
    step();
    flush2("t1");
    // 2: BLTU with borrow, predicted taken -> correct
    issue(1, 0, 3'b110, 4'b0100, 1, 32'h200, 32'h24);
    chk("t2_none", outs(), 32'b00000);
    step();
    chk("t2_none2", outs(), 32'b00000);
    // 3: BGE N=V taken correct; then N!=V not taken, mispredicted
    issue(1, 0, 3'b101, 4'b0011, 1, 32'h300, 32'h204);
    chk("t3a_none", outs(), 32'b00000);
    issue(1, 0, 3'b101, 4'b0001, 1, 32'h300, 32'h204);
    chk("t3b_redirect", outs(), 32'b11000);
    chk("t3b_pc", RedirectPC, 32'h204);
    step();
    flush2("t3b");
    // 4: BNE mispredict with RedirectReady held low; inputs changing meanwhile must be ignored
    RedirectReady = 0;
    issue(1, 0, 3'b001, 4'b0000, 0, 32'h400, 32'h34);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold", outs(), 32'b11000);
      chk("t4_pc", RedirectPC, 32'h400);
      BranchE = 1; Funct3E = 3'b000; FlagsE = 4'b1000; PCTargetE = 32'hdead; PCPlus4E = 32'hbeef;
      step();
    end
    chk("t4_hold_last", outs(), 32'b11000);
    chk("t4_pc_last", RedirectPC, 32'h400);
    BranchE = 0;
    RedirectReady = 1;
    step();
    flush2("t4");
    // 5: reserved funct3 -> illegal pulse, not taken, no redirect
    issue(1, 0, 3'b010, 4'b1111, 0, 32'h500, 32'h44);
    chk("t5_illegal", outs(), 32'b00001);
    step();
    chk("t5_illegal_end", outs(), 32'b00000);
    // jump wins over branch with reserved funct3: taken, no illegal pulse
    issue(1, 1, 3'b011, 4'b0000, 0, 32'h580, 32'h48);
    chk("jump_redirect", outs(), 32'b11000);
    chk("jump_pc", RedirectPC, 32'h580);
    step();
    flush2("jump");
    // 6: reset during first FLUSH cycle, then a fresh BLT mispredict
    issue(1, 0, 3'b000, 4'b1000, 0, 32'h5f0, 32'h4c);
    step();
    chk("t6_flush1", outs(), 32'b00110);
    RST = 1;
    step();
    chk("t6_reset_outs", outs(), 32'b0);
    chk("t6_reset_pc", RedirectPC, 32'h0);
    RST = 0;
    issue(1, 0, 3'b100, 4'b0001, 0, 32'h600, 32'h54);
    chk("t6_redirect", outs(), 32'b11000);
    chk("t6_pc", RedirectPC, 32'h600);
    step();
    flush2("t6");
`ifdef BRU_STATS_EN
    chk("stats_branch", BranchCount, 32'd1);
    chk("stats_mispred", MispredCount, 32'd1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
